// File: rtl/bfloat16_mac_tree_seq.sv
// ---------------------------------------------------------------------------
// bfloat16_mac_tree_seq
//
// Streaming sequencer for a 16-lane combinational bfloat16 adder tree.
// Operands arrive one per beat over a valid/ready input and are written into
// a registered 256-bit lane bus that feeds the external tree. After the final
// operand of a block (in_last, or the 16th beat) the lane bus is frozen, the
// sequencer waits SETTLE_CYCLES edges for the tree to settle, captures the
// tree sum and presents it on a valid/ready output. Lanes that receive no
// operand in a short block hold +0.0, so the sum covers only delivered data.
//
// Parameters
//   SETTLE_CYCLES  edges from the last-beat edge to the capture edge (1..15)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   sequencer accepts a beat (FILL only, low while rst is high)
//   in_data    bfloat16 operand
//   in_last    final operand of the block, qualified by the handshake
//   tree_in    registered lane bus, lane i at [16i+15:16i]
//   tree_out   combinational tree sum of tree_in
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   out_data   captured bfloat16 sum
//   out_count  number of operands delivered in the block (1..16)
//   busy       high while settling or holding a result
// ---------------------------------------------------------------------------
module bfloat16_mac_tree_seq #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_data,
  input  logic         in_last,
  output logic [255:0] tree_in,
  input  logic [15:0]  tree_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_data,
  output logic [4:0]   out_count,
  output logic         busy
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t        state;
  state_t        state_next;

  logic [3:0]    idx;
  logic [3:0]    idx_next;
  logic [3:0]    cnt;
  logic [3:0]    cnt_next;
  logic [255:0]  tree_in_next;
  logic [15:0]   out_data_next;
  logic [4:0]    out_count_next;

  logic          in_fire;
  logic          out_fire;
  logic          last_beat;

  // -------------------------------------------------------------------------
  // Handshake qualifiers
  // -------------------------------------------------------------------------
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  // The 16th beat closes the block even without in_last, so a 17th operand
  // can never land in the same block.
  assign last_beat = in_last | (idx == 4'd15);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      FILL: begin
        if (in_fire && last_beat) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == 4'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_fire) begin
          state_next = FILL;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  always_comb begin
    // rst gates in_ready directly so no beat is offered as accepted while
    // the sequencer is being held in reset.
    in_ready  = (state == FILL) && !rst;
    out_valid = (state == DONE);
    busy      = (state == SETTLE) || (state == DONE);
  end

  // -------------------------------------------------------------------------
  // Datapath next-value logic
  // -------------------------------------------------------------------------
  always_comb begin
    idx_next       = idx;
    cnt_next       = cnt;
    tree_in_next   = tree_in;
    out_data_next  = out_data;
    out_count_next = out_count;

    unique case (state)
      FILL: begin
        if (in_fire) begin
          // First beat of a block wipes every lane to +0.0 (additive
          // identity) so a short block never sums stale operands.
          if (idx == 4'd0) begin
            tree_in_next = '0;
          end
          tree_in_next[int'(idx) * 16 +: 16] = in_data;

          if (last_beat) begin
            out_count_next = {1'b0, idx} + 5'd1;
            cnt_next       = SETTLE_LOAD;
          end else begin
            idx_next = idx + 4'd1;
          end
        end
      end

      SETTLE: begin
        cnt_next = cnt - 4'd1;
        // tree_in has been frozen since the last-beat edge, so tree_out is
        // settled by the time cnt reaches 1.
        if (cnt == 4'd1) begin
          out_data_next = tree_out;
        end
      end

      DONE: begin
        if (out_fire) begin
          idx_next = 4'd0;
        end
      end

      default: begin
        idx_next = 4'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: the 256-bit lane bank is reset like any other register because
  // the tree must see a defined +0.0 on every lane straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= 4'd0;
      cnt       <= 4'd0;
      tree_in   <= '0;
      out_data  <= 16'h0000;
      out_count <= 5'd0;
    end else begin
      idx       <= idx_next;
      cnt       <= cnt_next;
      tree_in   <= tree_in_next;
      out_data  <= out_data_next;
      out_count <= out_count_next;
    end
  end

endmodule

// File: tb/tb_bfloat16_mac_tree_seq.sv
// ---------------------------------------------------------------------------
// tb_bfloat16_mac_tree_seq
//
// Self-checking bench for bfloat16_mac_tree_seq. A behavioural bfloat16 tree
// (via real arithmetic) drives tree_out from tree_in. Directed blocks are
// held in a table of {operands, expected sum, expected count}; backpressure
// and mid-block reset are hand-written sequences. Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_bfloat16_mac_tree_seq;

  localparam int SETTLE = 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic         in_last;
  logic [255:0] tree_in;
  logic [15:0]  tree_out;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic [4:0]   out_count;
  logic         busy;

  int tests_run;
  int tests_failed;

  bfloat16_mac_tree_seq #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .tree_in   (tree_in),
    .tree_out  (tree_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Behavioural tree: exact for the small values used here.
  // -------------------------------------------------------------------------
  function automatic real bf2r(input logic [15:0] b);
    real m;
    int  e;
    e = int'(b[14:7]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(int'(b[6:0])) / 128.0;
    while (e > 127) begin m = m * 2.0; e--; end
    while (e < 127) begin m = m / 2.0; e++; end
    return b[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] d;
    int          be;
    if (r == 0.0) return 16'h0000;
    d  = $realtobits(r);
    be = int'(d[62:52]) - 1023 + 127;
    return {d[63], be[7:0], d[51:45]};
  endfunction

  real tree_sum;
  always_comb begin
    tree_sum = 0.0;
    for (int i = 0; i < 16; i++) begin
      tree_sum = tree_sum + bf2r(tree_in[i*16 +: 16]);
    end
    tree_out = r2bf(tree_sum);
  end

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [15:0] ops [16];
    logic [15:0] exp_data;
    logic [4:0]  exp_count;
  } vec_t;

  vec_t vecs [4];

  // Drive one block from the table and check latency, result and lane bus.
  // With do_hs = 0 the task returns while the result is still pending.
  task automatic run_block(input int v, input bit do_hs);
    int           cycles;
    bit           accept_ok;
    bit           blocked_ok;
    logic [255:0] exp_lanes;

    accept_ok = 1'b1;
    exp_lanes = '0;
    for (int b = 0; b < vecs[v].n; b++) begin
      in_valid = 1'b1;
      in_data  = vecs[v].ops[b];
      in_last  = (b == vecs[v].n - 1);
      exp_lanes[b*16 +: 16] = vecs[v].ops[b];
      if (!in_ready) accept_ok = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'h0000;
    check($sformatf("%s accept", vecs[v].name), 256'(accept_ok), 256'(1));

    cycles     = 0;
    blocked_ok = 1'b1;
    while (!out_valid && cycles < 40) begin
      if (in_ready || !busy) blocked_ok = 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
    if (in_ready || !busy) blocked_ok = 1'b0;

    check($sformatf("%s latency", vecs[v].name), 256'(cycles), 256'(SETTLE));
    check($sformatf("%s in_ready low while busy", vecs[v].name),
          256'(blocked_ok), 256'(1));
    check($sformatf("%s out_data", vecs[v].name), 256'(out_data),
          256'(vecs[v].exp_data));
    check($sformatf("%s out_count", vecs[v].name), 256'(out_count),
          256'(vecs[v].exp_count));
    check($sformatf("%s tree_in", vecs[v].name), tree_in, exp_lanes);

    if (do_hs) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      check($sformatf("%s out_valid after handshake", vecs[v].name),
            256'(out_valid), 256'(0));
      check($sformatf("%s in_ready after handshake", vecs[v].name),
            256'(in_ready), 256'(1));
    end
  endtask

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [15:0]  held_data;
    logic [255:0] held_lanes;
    bit           stable_ok;

    tests_run    = 0;
    tests_failed = 0;

    // Full block: 16 x 1.0 = 16.0
    vecs[0].name = "full";   vecs[0].n = 16;
    for (int i = 0; i < 16; i++) vecs[0].ops[i] = 16'h3F80;
    vecs[0].exp_data = 16'h4180; vecs[0].exp_count = 5'd16;
    // Short block: 3 x 1.0 = 3.0, lanes 3..15 must be cleared
    vecs[1].name = "short";  vecs[1].n = 3;
    for (int i = 0; i < 16; i++) vecs[1].ops[i] = (i < 3) ? 16'h3F80 : 16'h0000;
    vecs[1].exp_data = 16'h4040; vecs[1].exp_count = 5'd3;
    // Single beat: 10.0
    vecs[2].name = "single"; vecs[2].n = 1;
    for (int i = 0; i < 16; i++) vecs[2].ops[i] = 16'h0000;
    vecs[2].ops[0] = 16'h4120;
    vecs[2].exp_data = 16'h4120; vecs[2].exp_count = 5'd1;
    // 0.75 + (-0.75) + 10.0 = 10.0
    vecs[3].name = "cancel"; vecs[3].n = 3;
    for (int i = 0; i < 16; i++) vecs[3].ops[i] = 16'h0000;
    vecs[3].ops[0] = 16'h3F40; vecs[3].ops[1] = 16'hBF40; vecs[3].ops[2] = 16'h4120;
    vecs[3].exp_data = 16'h4120; vecs[3].exp_count = 5'd3;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready",  256'(in_ready),  256'(0));
    check("reset tree_in",   tree_in,         256'(0));
    check("reset out_valid", 256'(out_valid), 256'(0));
    check("reset busy",      256'(busy),      256'(0));
    check("reset out_data",  256'(out_data),  256'(0));
    check("reset out_count", 256'(out_count), 256'(0));
    rst = 1'b0;
    #1;
    check("in_ready after release", 256'(in_ready), 256'(1));
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      run_block(v, 1'b1);
    end

    // Backpressure: result and lane bus held, input beats refused.
    out_ready = 1'b0;
    run_block(1, 1'b0);
    held_data  = out_data;
    held_lanes = tree_in;
    stable_ok  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 16'h4000 + 16'(c);
      in_last  = c[0];
      if (in_ready || !out_valid) stable_ok = 1'b0;
      @(posedge clk); #1;
      if (!out_valid || out_data !== held_data || tree_in !== held_lanes)
        stable_ok = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("backpressure hold", 256'(stable_ok), 256'(1));
    check("backpressure out_data", 256'(out_data), 256'(16'h4040));
    check("backpressure tree_in", tree_in, held_lanes);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("backpressure release in_ready", 256'(in_ready), 256'(1));
    check("backpressure release out_valid", 256'(out_valid), 256'(0));

    // Reset mid-block after 7 beats.
    for (int b = 0; b < 7; b++) begin
      in_valid = 1'b1;
      in_data  = 16'h3F80;
      in_last  = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("mid-block lanes loaded", 256'(tree_in[111:96]), 256'(16'h3F80));
    #2 rst = 1'b1;
    #1;
    check("async reset tree_in",   tree_in,         256'(0));
    check("async reset out_data",  256'(out_data),  256'(0));
    check("async reset out_count", 256'(out_count), 256'(0));
    check("async reset out_valid", 256'(out_valid), 256'(0));
    check("async reset busy",      256'(busy),      256'(0));
    check("async reset in_ready",  256'(in_ready),  256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("in_ready after mid reset", 256'(in_ready), 256'(1));
    run_block(0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bfloat16_mac_tree_seq.md
# bfloat16_mac_tree_seq

Streaming sequencer for the 16-lane combinational `bfloat16_mac_tree` adder. It collects bfloat16 operands one per beat over a valid/ready input, and drives them as a 256-bit lane bus into the tree. After a fixed settle time it captures the tree sum and presents it on a valid/ready output. Short blocks (`in_last` before 16 beats) are zero-padded so the tree sum covers only the delivered operands.

## Interface
- `SETTLE_CYCLES`, default 2: clock edges from the last-beat edge to the result-capture edge. Legal range 1..15.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `in_valid`  input  1  operand beat valid.
- `in_ready`  output  1  sequencer accepts a beat.
- `in_data`  input  16  bfloat16 operand.
- `in_last`  input  1  marks the final operand of the block; qualified by the handshake.
- `tree_in`  output  256  lane bus to the tree; lane i occupies `[16i+15:16i]`; registered.
- `tree_out`  input  16  tree sum of `tree_in`.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts the result.
- `out_data`  output  16  captured bfloat16 sum.
- `out_count`  output  5  number of delivered operands in the block, 1..16.
- `busy`  output  1  high in SETTLE or DONE.

## Operation
- States: FILL, SETTLE, DONE. Reset state is FILL with `idx` = 0.
- **FILL**
  - `in_ready` = 1, except that it is forced to 0 while `rst` is high.
  - On a handshake with `idx` = 0, all 16 lanes clear to 16'h0000 and lane 0 takes `in_data` in the same edge.
  - On a handshake with `idx` > 0, lane `idx` takes `in_data`.
  - If `in_last` = 1 or `idx` = 15 on the handshake: set `out_count` = `idx`+1, load `cnt` = `SETTLE_CYCLES`, and go to SETTLE.
  - Otherwise `idx` increments.
- **SETTLE**
  - `in_ready` = 0.
  - `cnt` decrements each edge.
  - On the edge where `cnt` = 1: `out_data` <= `tree_out`, go to DONE.
- **DONE**
  - `out_valid` = 1; `out_data` and `out_count` are held stable.
  - On `out_valid` && `out_ready`: go to FILL with `idx` = 0.
- `tree_in` holds its value from the last-beat edge until the first beat of the next block, so the tree is never disturbed while the result is pending.
- `in_last` on beat 16 is redundant and harmless. A 17th operand is never accepted into the same block.
- No arithmetic happens in this block. Zero padding uses +0.0 (16'h0000), which is the additive identity for the tree.
- Reset mid-operation (any state) discards the partial block and any pending result. After reset: FILL, `idx` = 0.

## Timing
- Reset values: `tree_in` = 0, `out_data` = 0, `out_count` = 0, `out_valid` = 0, `busy` = 0, `in_ready` = 0 while `rst` is high and 1 after release.
- One operand accepted per cycle in FILL; there are no bubbles between beats.
- Latency: last beat accepted at edge N → `out_valid` rises after edge N+`SETTLE_CYCLES`.
- Backpressure: `out_valid` stays high and `out_data` stays stable until `out_ready`. `in_ready` returns to 1 in the cycle after the output handshake edge.
- Input and output handshakes never occur in the same cycle, because there is no overlap between DONE and FILL.
- Block throughput: k beats + `SETTLE_CYCLES` + at least 1 output cycle.
- `in_data` and `in_last` are ignored when `in_valid` = 0 or `in_ready` = 0.

## Test plan
- **Full block:** reset, then 16 back-to-back beats of 16'h3F80 with `in_last` on beat 16 and `out_ready` = 1. Required: `out_data` = 16'h4180, `out_count` = 16, `out_valid` rises exactly `SETTLE_CYCLES` edges after the last beat.
- **Short block:** 3 beats of 16'h3F80 with `in_last` on beat 3. Required: `tree_in` lanes 3..15 = 0 (including stale data from a previous full block), `out_data` = 16'h4040, `out_count` = 3.
- **Single beat:** one beat of 16'h4120 with `in_last`. Required: `out_data` = 16'h4120, `out_count` = 1, `in_ready` = 0 during SETTLE and DONE.
- **Cancelling pair plus values:** beats 16'h3F40, 16'hBF40, 16'h4120 with `in_last`. Required: `out_data` = 16'h4120, `out_count` = 3.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles after `out_valid`. Required: `out_valid`, `out_data` and `tree_in` stable, `in_valid` pulses not accepted; after `out_ready` = 1, `in_ready` = 1 on the next cycle.
- **Reset mid-block:** assert `rst` asynchronously after 7 beats. Required: all outputs go to reset values immediately; a following 16-beat block of 16'h3F80 yields 16'h4180 with `out_count` = 16.
